// File: rtl/onchip_mem_burst_bridge.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM; one RAM word access per clock.
// Latency: a beat accepted at edge T is issued to the RAM in cycle T+1; read data returns in cycle T+2.
// Backpressure: waitrequest holds off masters for the whole read burst; read data itself cannot be stalled.
module onchip_mem_burst_bridge #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [BURST_W-1:0]    avs_burstcount,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_BURST = 2 ** (BURST_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BURST_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [BE_W-1:0]     mem_byteenable_q, mem_byteenable_d;
    logic                mem_chipselect_q, mem_chipselect_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic                mem_clken_q, mem_clken_d;
    logic                rdv_q, rdv_d;
    logic [BURST_W-1:0]  burst_eff;

    always_comb begin
        burst_eff = avs_burstcount;
        if (avs_burstcount == '0) begin
            burst_eff = BURST_W'(1);
        end else if (avs_burstcount > BURST_W'(MAX_BURST)) begin
            burst_eff = BURST_W'(MAX_BURST);
        end
    end

    // mem_clken_q doubles as "out of reset": nothing is accepted until the RAM clock is enabled.
    assign avs_waitrequest   = !mem_clken_q || (state_q == RD_BURST);
    assign avs_readdata      = mem_readdata;
    assign avs_readdatavalid = rdv_q;
    assign mem_address       = mem_address_q;
    assign mem_byteenable    = mem_byteenable_q;
    assign mem_chipselect    = mem_chipselect_q;
    assign mem_write         = mem_write_q;
    assign mem_writedata     = mem_writedata_q;
    assign mem_clken         = mem_clken_q;

    always_comb begin
        state_d          = state_q;
        remain_d         = remain_q;
        mem_address_d    = mem_address_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_writedata_d  = mem_writedata_q;
        mem_chipselect_d = 1'b0;
        mem_write_d      = 1'b0;
        mem_clken_d      = 1'b1;
        rdv_d            = mem_chipselect_q && !mem_write_q;

        case (state_q)
            IDLE: begin
                if (mem_clken_q) begin
                    // Write wins over a simultaneous (illegal) read.
                    if (avs_write) begin
                        mem_address_d    = avs_address;
                        mem_writedata_d  = avs_writedata;
                        mem_byteenable_d = avs_byteenable;
                        mem_chipselect_d = 1'b1;
                        mem_write_d      = 1'b1;
                        remain_d         = burst_eff - BURST_W'(1);
                        if (burst_eff != BURST_W'(1)) begin
                            state_d = WR_BURST;
                        end
                    end else if (avs_read) begin
                        mem_address_d    = avs_address;
                        mem_byteenable_d = {BE_W{1'b1}};
                        mem_chipselect_d = 1'b1;
                        remain_d         = burst_eff - BURST_W'(1);
                        state_d          = RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                // Stays one cycle past the last issue so the next command lands with the last beat.
                if (remain_q != '0) begin
                    mem_address_d    = mem_address_q + ADDR_W'(1);
                    mem_byteenable_d = {BE_W{1'b1}};
                    mem_chipselect_d = 1'b1;
                    remain_d         = remain_q - BURST_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (avs_write) begin
                    mem_address_d    = mem_address_q + ADDR_W'(1);
                    mem_writedata_d  = avs_writedata;
                    mem_byteenable_d = avs_byteenable;
                    mem_chipselect_d = 1'b1;
                    mem_write_d      = 1'b1;
                    remain_d         = remain_q - BURST_W'(1);
                    if (remain_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            remain_q         <= '0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_clken_q      <= 1'b0;
            rdv_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            remain_q         <= remain_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_clken_q      <= mem_clken_d;
            rdv_q            <= rdv_d;
        end
    end

endmodule
